// File: rtl/mc_controller_if.sv
// Interface: mc_controller_if
// Purpose : Bundles the instruction-field, status and control-select signals
//           exchanged between the multicycle MIPS control unit and its datapath.
// Modports:
//   master - the controller: reads op/funct/zero/memready, drives all controls
//   slave  - the datapath side: drives op/funct/zero/memready, reads controls
// Signals:
//   op[OPW-1:0], funct[FUNCTW-1:0]  instruction fields from the IR
//   zero, memready                  ALU zero flag, memory-access-complete
//   iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, pcen,
//   illegal, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]  datapath controls
interface mc_controller_if #(
  parameter int OPW    = 6,
  parameter int FUNCTW = 6
);
  logic [OPW-1:0]    op;
  logic [FUNCTW-1:0] funct;
  logic              zero;
  logic              memready;

  logic              iord;
  logic              memwrite;
  logic              irwrite;
  logic              regwrite;
  logic              regdst;
  logic              memtoreg;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic [1:0]        pcsrc;
  logic [2:0]        alucontrol;
  logic              pcen;
  logic              illegal;

  modport master (
    input  op, funct, zero, memready,
    output iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal
  );

  modport slave (
    output op, funct, zero, memready,
    input  iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal
  );
endinterface

// File: rtl/mc_controller.sv
// Module : mc_controller
// Purpose: Multicycle MIPS control unit. A Moore FSM sequences one instruction
//          at a time (lw, sw, R-type, beq, bne, addi, j) over a shared-memory
//          datapath, waiting on memready for every memory access, plus the
//          ALU decoder that turns the FSM's ALU operation into alucontrol.
// Ports  :
//   clk    rising-edge clock
//   reset  asynchronous, active-low; while low the FSM sits in FETCH and every
//          control output (enables, selects, illegal) is held at 0
//   bus    mc_controller_if.master - instruction fields, zero, memready in;
//          all datapath controls out
module mc_controller #(
  parameter int OPW    = 6,
  parameter int FUNCTW = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_controller_if.master      bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEX   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BREX   = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JEX    = 4'd11;

  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_RTYP = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  localparam logic [FUNCTW-1:0] FN_ADD = FUNCTW'(6'b100000);
  localparam logic [FUNCTW-1:0] FN_SUB = FUNCTW'(6'b100010);
  localparam logic [FUNCTW-1:0] FN_AND = FUNCTW'(6'b100100);
  localparam logic [FUNCTW-1:0] FN_OR  = FUNCTW'(6'b100101);
  localparam logic [FUNCTW-1:0] FN_SLT = FUNCTW'(6'b101010);

  // ALU operation requested by the FSM; ALUOP_NONE covers states that do not
  // use the ALU and leaves alucontrol at 0.
  localparam logic [1:0] ALUOP_NONE  = 2'd0;
  localparam logic [1:0] ALUOP_ADD   = 2'd1;
  localparam logic [1:0] ALUOP_SUB   = 2'd2;
  localparam logic [1:0] ALUOP_FUNCT = 2'd3;

  logic [3:0] state;
  logic [3:0] next_state;

  logic       iord_r, memwrite_r, irwrite_r, regwrite_r, regdst_r;
  logic       memtoreg_r, alusrca_r, illegal_r;
  logic       pcwrite, branch, branchne;
  logic [1:0] alusrcb_r, pcsrc_r, aluop;
  logic [2:0] alucontrol_r;
  logic [2:0] funct_ctl;
  logic       funct_ok;
  logic       pcen_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Memory states hold until memready; DECODE dispatches on the opcode and
  // falls back to FETCH for anything unsupported.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = bus.memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:   next_state = S_MEMADR;
          OP_RTYP:        next_state = S_RTEX;
          OP_BEQ, OP_BNE: next_state = S_BREX;
          OP_ADDI:        next_state = S_ADDIEX;
          OP_J:           next_state = S_JEX;
          default:        next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = bus.memready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = bus.memready ? S_FETCH : S_MEMWR;
      S_RTEX:   next_state = S_RTWB;
      S_RTWB:   next_state = S_FETCH;
      S_BREX:   next_state = S_FETCH;
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: next_state = S_FETCH;
      S_JEX:    next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // R-type funct decode; unknown functs still compute an add so RTWB writes
  // a defined value, but they raise illegal in RTEX.
  always_comb begin
    funct_ctl = 3'b010;
    funct_ok  = 1'b1;
    case (bus.funct)
      FN_ADD:  funct_ctl = 3'b010;
      FN_SUB:  funct_ctl = 3'b110;
      FN_AND:  funct_ctl = 3'b000;
      FN_OR:   funct_ctl = 3'b001;
      FN_SLT:  funct_ctl = 3'b111;
      default: begin
        funct_ctl = 3'b010;
        funct_ok  = 1'b0;
      end
    endcase
  end

  // Moore decode of the state register. FETCH's irwrite/pcwrite are the only
  // outputs qualified by memready.
  always_comb begin
    iord_r     = 1'b0;
    memwrite_r = 1'b0;
    irwrite_r  = 1'b0;
    regwrite_r = 1'b0;
    regdst_r   = 1'b0;
    memtoreg_r = 1'b0;
    alusrca_r  = 1'b0;
    alusrcb_r  = 2'b00;
    pcsrc_r    = 2'b00;
    aluop      = ALUOP_NONE;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    illegal_r  = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb_r = 2'b01;
        aluop     = ALUOP_ADD;
        irwrite_r = bus.memready;
        pcwrite   = bus.memready;
      end
      S_DECODE: begin
        alusrcb_r = 2'b11;
        aluop     = ALUOP_ADD;
        case (bus.op)
          OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegal_r = 1'b0;
          default: illegal_r = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca_r = 1'b1;
        alusrcb_r = 2'b10;
        aluop     = ALUOP_ADD;
      end
      S_MEMRD: iord_r = 1'b1;
      S_MEMWB: begin
        regwrite_r = 1'b1;
        memtoreg_r = 1'b1;
      end
      S_MEMWR: begin
        iord_r     = 1'b1;
        memwrite_r = 1'b1;
      end
      S_RTEX: begin
        alusrca_r = 1'b1;
        aluop     = ALUOP_FUNCT;
        illegal_r = ~funct_ok;
      end
      S_RTWB: begin
        regwrite_r = 1'b1;
        regdst_r   = 1'b1;
      end
      S_BREX: begin
        alusrca_r = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_r   = 2'b01;
        branch    = (bus.op == OP_BEQ);
        branchne  = (bus.op == OP_BNE);
      end
      S_ADDIEX: begin
        alusrca_r = 1'b1;
        alusrcb_r = 2'b10;
        aluop     = ALUOP_ADD;
      end
      S_ADDIWB: regwrite_r = 1'b1;
      S_JEX: begin
        pcsrc_r = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
        iord_r = 1'b0;
      end
    endcase
  end

  always_comb begin
    alucontrol_r = 3'b000;
    case (aluop)
      ALUOP_ADD:   alucontrol_r = 3'b010;
      ALUOP_SUB:   alucontrol_r = 3'b110;
      ALUOP_FUNCT: alucontrol_r = funct_ctl;
      default:     alucontrol_r = 3'b000;
    endcase
  end

  assign pcen_r = pcwrite | (branch & bus.zero) | (branchne & ~bus.zero);

  // Every output is gated by reset so an abandoned instruction cannot write
  // anything, even in the part of the cycle before the next clock edge.
  assign bus.iord       = reset & iord_r;
  assign bus.memwrite   = reset & memwrite_r;
  assign bus.irwrite    = reset & irwrite_r;
  assign bus.regwrite   = reset & regwrite_r;
  assign bus.regdst     = reset & regdst_r;
  assign bus.memtoreg   = reset & memtoreg_r;
  assign bus.alusrca    = reset & alusrca_r;
  assign bus.alusrcb    = reset ? alusrcb_r : 2'b00;
  assign bus.pcsrc      = reset ? pcsrc_r : 2'b00;
  assign bus.alucontrol = reset ? alucontrol_r : 3'b000;
  assign bus.pcen       = reset & pcen_r;
  assign bus.illegal    = reset & illegal_r;

endmodule
